// File: rtl/tag_array_pkg.sv
// Shared types and helpers for the parity-protected tag array.
package tag_array_pkg;

    // Widest parity group the helper accepts; narrower groups are zero-extended.
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Number of parity groups covering a data word.
    function automatic int unsigned npar(input int unsigned data_w, input int unsigned pgrp_w);
        return data_w / pgrp_w;
    endfunction

    // Odd-parity bit: makes the total count of ones across {v, p} odd.
    function automatic logic par_odd(input logic [PAR_MAX_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/tag_array_par_ram.sv
// Behavioural single-port synchronous RAM; array has no reset, only the read register does.
module tag_ram_sp #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WIDTH  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Array write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register only updates on reads, so it holds the last read word otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tag_array_par.sv
// Parametrised tag store: single-port RAM with per-group odd parity and a flush sweep.
module tag_array_par
    import tag_array_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 8,
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       PGRP_W         = 16,
    parameter logic [DATA_W-1:0] INIT_VAL       = '0,
    parameter bit                FLUSH_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/PGRP_W-1:0]   inj_perr,
    input  logic                       flush_req,
    output logic                       ack,
    output logic [DATA_W-1:0]          rdata,
    output logic [DATA_W/PGRP_W-1:0]   perr,
    output logic                       busy,
    output logic                       flush_done
);

    localparam int unsigned       NPAR     = npar(DATA_W, PGRP_W);
    localparam int unsigned       RAM_W    = DATA_W + NPAR;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    // Per-group odd parity of a data word.
    function automatic logic [NPAR-1:0] gen_par(input logic [DATA_W-1:0] d);
        logic [PAR_MAX_W-1:0] grp;
        logic [NPAR-1:0]      p;
        for (int unsigned g = 0; g < NPAR; g++) begin
            grp             = '0;
            grp[PGRP_W-1:0] = d[g*PGRP_W +: PGRP_W];
            p[g]            = par_odd(grp);
        end
        return p;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              flush_done_q, flush_done_d;
    logic              perr_en_q, perr_en_d;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  ram_wdata;
    logic [RAM_W-1:0]  ram_rdata;

    // Next-state, flush counter and RAM port steering.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack_d        = 1'b0;
        flush_done_d = 1'b0;
        perr_en_d    = perr_en_q;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = addr;
        ram_wdata    = {gen_par(wdata) ^ inj_perr, wdata};
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (req) begin
                    ram_en    = 1'b1;
                    ram_we    = we;
                    ack_d     = 1'b1;
                    perr_en_d = ~we;
                end
            end
            FLUSH: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = {gen_par(INIT_VAL), INIT_VAL};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FLUSH_ON_RESET ? FLUSH : IDLE;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            flush_done_q <= 1'b0;
            perr_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            flush_done_q <= flush_done_d;
            perr_en_q    <= perr_en_d;
        end
    end

    tag_ram_sp #(
        .ADDR_W (ADDR_W),
        .WIDTH  (RAM_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Parity check on the registered read word; the RAM read register doubles as the
    // rdata output register, and perr is forced low after a write or reset.
    always_comb begin
        perr = '0;
        if (perr_en_q) begin
            perr = gen_par(ram_rdata[DATA_W-1:0]) ^ ram_rdata[RAM_W-1:DATA_W];
        end
    end

    assign rdata      = ram_rdata[DATA_W-1:0];
    assign ack        = ack_q;
    assign busy       = (state_q == FLUSH);
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_tag_array_par.sv
// Self-checking bench for tag_array_par: default 256x16 instance plus a 16x32 / 4-group instance.
module tb_tag_array_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst, req, we, flush_req;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [0:0]  inj_perr;
    logic        ack, busy, flush_done;
    logic [15:0] rdata;
    logic [0:0]  perr;

    // Wide instance
    logic        rst2, req2, we2, flush_req2;
    logic [3:0]  addr2;
    logic [31:0] wdata2;
    logic [3:0]  inj2;
    logic        ack2, busy2, flush_done2;
    logic [31:0] rdata2;
    logic [3:0]  perr2;

    localparam logic [31:0] INIT2 = 32'h1234_00A5;

    tag_array_par dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .inj_perr(inj_perr), .flush_req(flush_req), .ack(ack), .rdata(rdata),
        .perr(perr), .busy(busy), .flush_done(flush_done)
    );

    tag_array_par #(
        .ADDR_W(4), .DATA_W(32), .PGRP_W(8), .INIT_VAL(INIT2), .FLUSH_ON_RESET(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst2), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .inj_perr(inj2), .flush_req(flush_req2), .ack(ack2), .rdata(rdata2),
        .perr(perr2), .busy(busy2), .flush_done(flush_done2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: stored word and which groups were written with bad parity.
    logic [15:0] m_data [256];
    logic        m_inj  [256];
    logic [15:0] m_rdata;
    logic        m_perr;
    logic [31:0] m2_data [16];
    logic [3:0]  m2_inj  [16];
    logic [31:0] m2_rdata;
    logic [3:0]  m2_perr;

    task automatic model_flush();
        for (int i = 0; i < 256; i++) begin
            m_data[i] = 16'h0000;
            m_inj[i]  = 1'b0;
        end
    endtask

    task automatic model2_flush();
        for (int i = 0; i < 16; i++) begin
            m2_data[i] = INIT2;
            m2_inj[i]  = 4'b0000;
        end
    endtask

    // One access on the default instance; leaves req asserted so calls chain back-to-back.
    task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d, input logic i);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; inj_perr = i;
        @(posedge clk); #1;
        if (w) begin
            m_data[a] = d; m_inj[a] = i; m_perr = 1'b0;
        end else begin
            m_rdata = m_data[a]; m_perr = m_inj[a];
        end
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL ack a=%h w=%b: got %b expected 1", a, w, ack); end
        tests++; if (rdata !== m_rdata) begin fails++; $display("FAIL rdata a=%h w=%b: got %h expected %h", a, w, rdata, m_rdata); end
        tests++; if (perr !== m_perr) begin fails++; $display("FAIL perr a=%h w=%b: got %b expected %b", a, w, perr, m_perr); end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req = 1'b0; flush_req = 1'b0;
        @(posedge clk); #1;
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL idle_ack: got %b expected 0", ack); end
        tests++; if (rdata !== m_rdata) begin fails++; $display("FAIL idle_rdata_hold: got %h expected %h", rdata, m_rdata); end
        tests++; if (perr !== m_perr) begin fails++; $display("FAIL idle_perr_hold: got %b expected %b", perr, m_perr); end
    endtask

    // Counts edges until flush_done is seen (bounded); called right after the edge that starts the sweep.
    task automatic wait_flush(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (flush_done === 1'b1) break;
            if (n == 128) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_mid_flush: got %b expected 1", busy); end
            end
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL ack_during_flush: got %b expected 0", ack); end
        end
        model_flush();
    endtask

    task automatic access2(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] i);
        @(negedge clk);
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; inj2 = i;
        @(posedge clk); #1;
        if (w) begin
            m2_data[a] = d; m2_inj[a] = i; m2_perr = 4'b0000;
        end else begin
            m2_rdata = m2_data[a]; m2_perr = m2_inj[a];
        end
        tests++; if (ack2 !== 1'b1) begin fails++; $display("FAIL ack2 a=%h: got %b expected 1", a, ack2); end
        tests++; if (rdata2 !== m2_rdata) begin fails++; $display("FAIL rdata2 a=%h: got %h expected %h", a, rdata2, m2_rdata); end
        tests++; if (perr2 !== m2_perr) begin fails++; $display("FAIL perr2 a=%h: got %b expected %b", a, perr2, m2_perr); end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; rst2 = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; inj_perr = '0; flush_req = 1'b0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; inj2 = '0; flush_req2 = 1'b0;
        m_rdata = '0; m_perr = 1'b0; m2_rdata = '0; m2_perr = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", ack); end
        tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        tests++; if (perr !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", perr); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        wait_flush(n);
        tests++; if (n != 256) begin fails++; $display("FAIL reset_sweep_len: got %0d expected 256", n); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || flush_done !== 1'b0) begin fails++; $display("FAIL post_sweep busy/done: got %b%b expected 00", busy, flush_done); end
        model2_flush();
        access(1'b0, 8'h00, '0, 1'b0);
        access(1'b0, 8'h7F, '0, 1'b0);
        access(1'b0, 8'hFF, '0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_write_read();
        access(1'b1, 8'h12, 16'hA5C3, 1'b0);
        access(1'b0, 8'h12, '0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_inj_perr();
        access(1'b1, 8'h40, 16'hFFFF, 1'b1);
        access(1'b0, 8'h40, '0, 1'b0);
        idle_cycle();
        access(1'b1, 8'h40, 16'hFFFF, 1'b0);
        access(1'b0, 8'h40, '0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 16'($urandom),
                       1'($urandom_range(0, 7) == 0));
            end
        end
        idle_cycle();
    endtask

    task automatic test_flush_collision();
        int n;
        @(negedge clk);
        flush_req = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h12;
        @(posedge clk); #1;
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL collision_ack: got %b expected 0", ack); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL collision_busy: got %b expected 1", busy); end
        flush_req = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            flush_req = (n == 50);
            if (flush_done === 1'b1) break;
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL req_during_flush_ack: got %b expected 0", ack); end
        end
        req = 1'b0; flush_req = 1'b0;
        model_flush();
        tests++; if (n != 256) begin fails++; $display("FAIL collision_sweep_len: got %0d expected 256", n); end
        access(1'b0, 8'h12, '0, 1'b0);
        access(1'b0, 8'h40, '0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_reset_mid_flush();
        int n;
        access(1'b1, 8'h33, 16'h8000 | 16'($urandom), 1'b0);
        access(1'b0, 8'h33, '0, 1'b0);
        idle_cycle();
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m_rdata = '0; m_perr = 1'b0;
        tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL async_rst_rdata: got %h expected 0", rdata); end
        tests++; if (ack !== 1'b0 || flush_done !== 1'b0 || perr !== 1'b0) begin fails++; $display("FAIL async_rst_outs: got ack=%b done=%b perr=%b expected 0", ack, flush_done, perr); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL async_rst_busy: got %b expected 1", busy); end
        @(negedge clk);
        rst = 1'b0;
        wait_flush(n);
        tests++; if (n != 256) begin fails++; $display("FAIL restart_sweep_len: got %0d expected 256", n); end
        access(1'b0, 8'h33, '0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_wide_variant();
        int n;
        @(negedge clk);
        flush_req2 = 1'b1;
        @(posedge clk); #1;
        flush_req2 = 1'b0;
        tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL wide_busy: got %b expected 1", busy2); end
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (flush_done2 === 1'b1) break;
        end
        model2_flush();
        tests++; if (n != 16) begin fails++; $display("FAIL wide_sweep_len: got %0d expected 16", n); end
        access2(1'b0, 4'h9, '0, 4'b0000);
        access2(1'b1, 4'h5, 32'hDEAD_BEEF, 4'b0100);
        access2(1'b0, 4'h5, '0, 4'b0000);
        for (int k = 0; k < 40; k++) begin
            access2(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        req2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_inj_perr();
        test_back_to_back_random();
        test_flush_collision();
        test_reset_mid_flush();
        test_wide_variant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
